// File: rtl/ntt_result_unloader_pkg.sv
// Shared constants for the NTT result unloader: default widths, RAM indices,
// FSM encoding and the coefficient-index to RAM mapping.
package ntt_result_unloader_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] RAM0 = 2'd0;
  localparam logic [1:0] RAM1 = 2'd1;
  localparam logic [1:0] RAM2 = 2'd2;
  localparam logic [1:0] RAM3 = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // hi is the top bit of the coefficient index: it picks the second RAM of the pair
  function automatic logic [1:0] ram_index(input logic sel_bank, input logic hi);
    logic [1:0] idx;
    case ({sel_bank, hi})
      2'b00:   idx = RAM2;
      2'b01:   idx = RAM3;
      2'b10:   idx = RAM0;
      2'b11:   idx = RAM1;
      default: idx = RAM0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ntt_result_unloader_skid.sv
// Two-entry FIFO between the RAM read pipeline and the output stream.
// The head register drives the stream directly and is zeroed when the FIFO empties.
module ntt_skid_fifo2
  import ntt_result_unloader_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;

  // Storage and occupancy update; the credit logic upstream guarantees no push into a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {W{1'b0}};
      r_tail  <= {W{1'b0}};
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_head  <= {W{1'b0}};
      r_tail  <= {W{1'b0}};
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= i_data;
          end else begin
            r_tail <= i_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= (r_count == 2'd2) ? r_tail : {W{1'b0}};
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/ntt_result_unloader.sv
// Drains the 2*DEPTH final NTT coefficients from the result bank pair in natural
// order and presents them as a valid/ready stream with a last tag.
module ntt_result_unloader
  import ntt_result_unloader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bank_sel,
  input  logic              abort,
  output logic [3:0]        ram_ena,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout0,
  input  logic [DATA_W-1:0] ram_dout1,
  input  logic [DATA_W-1:0] ram_dout2,
  input  logic [DATA_W-1:0] ram_dout3,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] K_LAST = {(ADDR_W+1){1'b1}};
  localparam logic [ADDR_W:0] K_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic              r_bank_sel;
  logic [ADDR_W:0]   r_k;
  logic              r_inflight;
  logic              r_rd_last;
  logic [1:0]        r_rd_idx;

  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_credit;
  logic [1:0]        w_ram_idx;
  logic [1:0]        w_fifo_count;
  logic              w_fifo_valid;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W:0]   w_head;

  // A read may be issued only if its data will find room once it lands
  assign w_pop     = w_fifo_valid & m_ready;
  assign w_credit  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == ST_READ) & ~abort & (w_credit < 3'd2);
  assign w_ram_idx = ram_index(r_bank_sel, r_k[ADDR_W]);
  assign ram_addr  = r_k[ADDR_W-1:0];

  // One-hot port-A enable for the RAM holding coefficient k
  always_comb begin
    ram_ena = 4'b0000;
    if (w_issue) begin
      ram_ena[w_ram_idx] = 1'b1;
    end else begin
      ram_ena = 4'b0000;
    end
  end

  // Return-data select follows the RAM that was read in the previous cycle
  always_comb begin
    case (r_rd_idx)
      RAM0:    w_rd_data = ram_dout0;
      RAM1:    w_rd_data = ram_dout1;
      RAM2:    w_rd_data = ram_dout2;
      RAM3:    w_rd_data = ram_dout3;
      default: w_rd_data = ram_dout0;
    endcase
  end

  // Control FSM and coefficient index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bank_sel <= 1'b0;
      r_k        <= {(ADDR_W+1){1'b0}};
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_k     <= {(ADDR_W+1){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_READ;
            r_bank_sel <= bank_sel;
            r_k        <= {(ADDR_W+1){1'b0}};
          end
        end
        ST_READ: begin
          if (w_issue) begin
            if (r_k == K_LAST) begin
              r_state <= ST_DRAIN;
            end else begin
              r_k <= r_k + K_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop & m_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pending-read tracking; an abort suppresses issue, so its in-flight data is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_idx   <= RAM0;
    end else begin
      r_inflight <= w_issue;
      r_rd_last  <= w_issue & (r_k == K_LAST);
      r_rd_idx   <= w_ram_idx;
    end
  end

  ntt_skid_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (abort),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  ({r_rd_last, w_rd_data}),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign m_data  = w_head[DATA_W-1:0];
  assign m_last  = w_head[DATA_W];
  assign m_valid = w_fifo_valid;
  assign busy    = (r_state == ST_READ) | (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_ntt_result_unloader.sv
// Scoreboard bench for ntt_result_unloader: behavioural RAMs, a reference coefficient
// map, and a negedge monitor that checks every handshake, stall hold and done pulse.
module tb_ntt_result_unloader;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int D  = 128;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          bank_sel;
  logic          abort;
  logic [3:0]    ram_ena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout0, ram_dout1, ram_dout2, ram_dout3;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  ntt_result_unloader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel), .abort(abort),
    .ram_ena(ram_ena), .ram_addr(ram_addr),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2), .ram_dout3(ram_dout3),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic [DW-1:0] mem [4][D];
  exp_t          exp_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic cur_bank = 1'b0;
  bit   expect_done = 1'b0;
  int   done_cnt = 0;
  int   issued = 0, accepted = 0, max_out = 0, run_acc = 0, wrong_pair = 0;
  bit   prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int   first_ena_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, t0 = 0;
  logic [3:0] first_ena_val = 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAMs: data appears the cycle after the enable edge
  always @(posedge clk) begin
    if (ram_ena[0]) ram_dout0 <= mem[0][ram_addr];
    if (ram_ena[1]) ram_dout1 <= mem[1][ram_addr];
    if (ram_ena[2]) ram_dout2 <= mem[2][ram_addr];
    if (ram_ena[3]) ram_dout3 <= mem[3][ram_addr];
  end

  task automatic check(input logic ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Coefficient k of the result set: first DEPTH words from the lower RAM of the pair
  function automatic logic [DW-1:0] ref_word(input logic bs, input int k);
    int pair;
    pair = bs ? 0 : 2;
    if (k < D) return mem[pair][k];
    else       return mem[pair+1][k-D];
  endfunction

  // mode 0: all random; 1: counting pattern in ram2/ram3; 2: counting pattern in ram0/ram1
  task automatic preload(input int mode);
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < D; a++)
        mem[r][a] = DW'($urandom);
    if (mode != 0) begin
      for (int a = 0; a < D; a++) begin
        mem[(mode == 1) ? 2 : 0][a] = DW'(a);
        mem[(mode == 1) ? 3 : 1][a] = DW'(32'h100 + a);
      end
    end
  endtask

  task automatic do_start(input logic bs);
    exp_t e;
    start = 1'b1; bank_sel = bs; cur_bank = bs; t0 = cyc + 1; run_acc = 0;
    first_ena_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1;
    for (int k = 0; k < N; k++) begin
      e.data = ref_word(bs, k);
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int duty);
    int d0;
    int n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      m_ready = (int'($urandom_range(0, 99)) < duty);
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b1;
    check(done_cnt != d0, "done_timeout", n, budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(ram_ena == 4'b0000, {tag, "_ram_ena"}, ram_ena, 0);
    check(ram_addr == 7'd0, {tag, "_ram_addr"}, ram_addr, 0);
    check(m_valid == 1'b0, {tag, "_m_valid"}, m_valid, 0);
    check(m_data == 16'd0, {tag, "_m_data"}, m_data, 0);
    check(m_last == 1'b0, {tag, "_m_last"}, m_last, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(done == 1'b0, {tag, "_done"}, done, 0);
  endtask

  // Monitor: samples mid-cycle, ahead of the edge where the handshake lands
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      issued = 0; accepted = 0; expect_done = 1'b0; prev_stall = 1'b0;
    end else begin
      if (done || expect_done) begin
        check(done == expect_done, "done_pulse", done, expect_done);
        if (done) done_cnt++;
      end
      expect_done = 1'b0;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (ram_ena != 4'b0000) begin
        issued++;
        if (first_ena_cyc < 0) begin
          first_ena_cyc = cyc;
          first_ena_val = ram_ena;
        end
        if ($countones(ram_ena) != 1 ||
            (cur_bank ? (ram_ena[3:2] != 2'b00) : (ram_ena[1:0] != 2'b00)))
          wrong_pair++;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall)
        check(m_valid && m_data == prev_data && m_last == prev_last, "stall_hold",
              {15'd0, m_valid, m_data}, {15'd0, 1'b1, prev_data});
      if (m_valid && m_ready) begin
        check(exp_q.size() != 0, "unexpected_word", m_data, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(m_data == e.data, "data", m_data, e.data);
          check(m_last == e.last, "last", m_last, e.last);
          if (e.last) begin
            last_hs_cyc = cyc;
            expect_done = !abort;
          end
        end
        accepted++;
        run_acc++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (abort) begin
        exp_q.delete();
        issued = 0; accepted = 0; prev_stall = 1'b0; expect_done = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int dc;
    logic bs;
    rst_n = 1'b0; start = 1'b0; bank_sel = 1'b0; abort = 1'b0; m_ready = 1'b1;
    preload(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Counting pattern from ram2/ram3, full-rate, with latency checks
    preload(1);
    do_start(1'b0);
    wait_done(600, 100);
    check(first_ena_cyc == t0, "first_ena_cycle", first_ena_cyc, t0);
    check(first_ena_val == 4'b0100, "first_ena_b0", first_ena_val, 4'b0100);
    check(first_valid_cyc == t0 + 2, "first_valid_cycle", first_valid_cyc, t0 + 2);
    check(last_hs_cyc == t0 + 257, "last_accept_cycle", last_hs_cyc, t0 + 257);
    check(exp_q.size() == 0, "queue_empty_1", exp_q.size(), 0);

    // Same pattern from ram0/ram1
    preload(2);
    wrong_pair = 0;
    do_start(1'b1);
    wait_done(600, 100);
    check(first_ena_val == 4'b0001, "first_ena_b1", first_ena_val, 4'b0001);
    check(last_hs_cyc == t0 + 257, "last_accept_cycle_b1", last_hs_cyc, t0 + 257);
    check(wrong_pair == 0, "wrong_pair_b1", wrong_pair, 0);
    check(exp_q.size() == 0, "queue_empty_2", exp_q.size(), 0);

    // Random data, random bank, 30% ready duty
    preload(0);
    bs = ($urandom_range(0, 1) == 1);
    max_out = 0;
    do_start(bs);
    wait_done(4000, 30);
    check(max_out <= 2, "max_buffered", max_out, 2);
    check(exp_q.size() == 0, "queue_empty_3", exp_q.size(), 0);

    // Abort at word 50, then immediate restart on the other pair
    preload(0);
    do_start(1'b0);
    n = 0;
    while (run_acc < 50 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(run_acc >= 50, "reach_word50", run_acc, 50);
    abort = 1'b1;
    @(posedge clk); #1;
    check(m_valid == 1'b0, "abort_m_valid", m_valid, 0);
    check(busy == 1'b0, "abort_busy", busy, 0);
    abort = 1'b0;
    dc = done_cnt;
    do_start(1'b1);
    wait_done(600, 100);
    check(done_cnt == dc + 1, "done_count_after_abort", done_cnt, dc + 1);
    check(exp_q.size() == 0, "queue_empty_5", exp_q.size(), 0);

    // Spurious start mid-unload is ignored
    preload(0);
    wrong_pair = 0;
    do_start(1'b0);
    repeat (40) @(posedge clk);
    #1;
    start = 1'b1; bank_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(600, 100);
    check(wrong_pair == 0, "wrong_pair_restart", wrong_pair, 0);
    check(exp_q.size() == 0, "queue_empty_6a", exp_q.size(), 0);

    // Asynchronous reset mid-unload, then a clean run
    do_start(1'b1);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check(busy == 1'b0 && m_valid == 1'b0, "post_reset_idle", {busy, m_valid}, 0);
    end
    preload(0);
    do_start(1'b0);
    wait_done(600, 100);
    check(exp_q.size() == 0, "queue_empty_6b", exp_q.size(), 0);
    check(wrong_pair == 0, "wrong_pair_final", wrong_pair, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
